// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - sequences RX bytes (A, B, opcode) into the registered ALU and returns the result on TX.
// Optional macro ALU_CTRL_FLAGS_TX_EN: also transmit a {6'b0, zero, overflow} flags byte after the result.
module alu_uart_ctrl #(
    parameter int N    = 8,
    parameter int NSel = 6
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_done,
    input  logic            i_tx_done,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_start,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    input  logic [N-1:0]    i_alu_Result,
    input  logic            i_alu_overflow,
    input  logic            i_alu_zero,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        CAPTURE,
        SEND
`ifdef ALU_CTRL_FLAGS_TX_EN
        , SEND_FLAGS
`endif
    } state_t;

    state_t          state, state_next;
    logic [N-1:0]    alu_a_next, alu_b_next;
    logic [NSel-1:0] alu_op_next;
    logic [7:0]      tx_data_next;
    logic            tx_start_next;

`ifdef ALU_CTRL_FLAGS_TX_EN
    logic [7:0] flags, flags_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            flags <= 8'h00;
        end else begin
            flags <= flags_next;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = i_alu_zero | i_alu_overflow;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= GET_A;
            o_alu_A    <= '0;
            o_alu_B    <= '0;
            o_alu_Op   <= '0;
            o_tx_data  <= 8'h00;
            o_tx_start <= 1'b0;
        end else begin
            state      <= state_next;
            o_alu_A    <= alu_a_next;
            o_alu_B    <= alu_b_next;
            o_alu_Op   <= alu_op_next;
            o_tx_data  <= tx_data_next;
            o_tx_start <= tx_start_next;
        end
    end

    // o_tx_start defaults low, so every start is a single-cycle pulse;
    // a tx_done coinciding with that pulse belongs to an earlier byte and is ignored.
    always_comb begin
        state_next    = state;
        alu_a_next    = o_alu_A;
        alu_b_next    = o_alu_B;
        alu_op_next   = o_alu_Op;
        tx_data_next  = o_tx_data;
        tx_start_next = 1'b0;
`ifdef ALU_CTRL_FLAGS_TX_EN
        flags_next    = flags;
`endif
        case (state)
            GET_A: begin
                if (i_rx_done) begin
                    alu_a_next = i_rx_data[N-1:0];
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    alu_b_next = i_rx_data[N-1:0];
                    state_next = GET_OP;
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    alu_op_next = i_rx_data[NSel-1:0];
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                tx_data_next  = 8'(i_alu_Result);
                tx_start_next = 1'b1;
`ifdef ALU_CTRL_FLAGS_TX_EN
                flags_next    = {6'b0, i_alu_zero, i_alu_overflow};
`endif
                state_next    = SEND;
            end
            SEND: begin
                if (i_tx_done && !o_tx_start) begin
`ifdef ALU_CTRL_FLAGS_TX_EN
                    tx_data_next  = flags;
                    tx_start_next = 1'b1;
                    state_next    = SEND_FLAGS;
`else
                    state_next    = GET_A;
`endif
                end
            end
`ifdef ALU_CTRL_FLAGS_TX_EN
            SEND_FLAGS: begin
                if (i_tx_done && !o_tx_start) begin
                    state_next = GET_A;
                end
            end
`endif
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    assign o_busy = (state != GET_A);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - self-checking bench for alu_uart_ctrl with a registered ALU stub.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic       alu_zero;
    logic       busy;
    logic       stub_mode;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(.N(8), .NSel(6)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_tx_done      (tx_done),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_alu_A        (alu_a),
        .o_alu_B        (alu_b),
        .o_alu_Op       (alu_op),
        .i_alu_Result   (alu_result),
        .i_alu_overflow (alu_ovf),
        .i_alu_zero     (alu_zero),
        .o_busy         (busy)
    );

    function automatic logic [7:0] stub_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    // Registered ALU standing in for the real instance; stub_mode forces the fixed flags-test outputs.
    always_ff @(posedge clk) begin
        alu_result <= stub_mode ? 8'h80 : stub_alu(alu_a, alu_b, alu_op);
    end
    assign alu_ovf  = stub_mode;
    assign alu_zero = stub_mode ? 1'b0 : (alu_result == 8'h00);

    function automatic int ref_result(input int a, input int b, input int op_byte);
        int op;
        op = op_byte % 64;
        if (op == 32) return (a + b) % 256;
        if (op == 34) return (a - b + 256) % 256;
        if (op == 36) return a & b;
        if (op == 37) return a | b;
        if (op == 38) return a ^ b;
        if (op == 39) return 255 - (a | b);
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic wait_tx(output logic [7:0] data, output int cyc);
        cyc = 0;
        while (!tx_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!tx_start) check("tx_start_timeout", 0, 1);
        data = tx_data;
    endtask

    task automatic finish_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        logic [7:0] d;
        int         cyc;
        int         starts;
        logic [7:0] base_ops[8];

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'h09, 8'h04, 8'h22, 8'h05};
        vecs[2] = '{8'h0C, 8'h0A, 8'h24, 8'h08};
        vecs[3] = '{8'h05, 8'h03, 8'h3F, 8'h00};
        vecs[4] = '{8'hFF, 8'h01, 8'h20, 8'h00};
        vecs[5] = '{8'h03, 8'h05, 8'hE2, 8'hFE};
        base_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h3F, 8'h00};

        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00; stub_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_start", tx_start, 0);
        check("reset_busy", busy, 0);

        // Reset in the middle of a sequence discards the partial operands
        send_byte(8'h05);
        send_byte(8'h03);
        check("midseq_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        check("midrst_busy", busy, 0);
        send_op(8'h02, 8'h04, 8'h20);
        check("post_rst_alu_a", alu_a, 2);
        check("post_rst_alu_b", alu_b, 4);
        wait_tx(d, cyc);
        check("post_rst_tx", d, 8'h06);
        finish_tx();
        check("post_rst_idle", busy, 0);

        // ADD with latency, then dropped RX bytes while waiting in SEND
        send_op(8'h05, 8'h03, 8'h20);
        check("add_alu_op", alu_op, 8'h20);
        wait_tx(d, cyc);
        check("add_latency", cyc, 2);
        check("add_tx", d, 8'h08);
        @(negedge clk);
        check("add_start_pulse", tx_start, 0);
        send_byte(8'hAA);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
            if (tx_data != 8'h08) check("drop_tx_stable", tx_data, 8'h08);
        end
        check("drop_extra_starts", starts, 0);
        check("drop_alu_a", alu_a, 5);
        check("drop_alu_b", alu_b, 3);
        check("drop_alu_op", alu_op, 8'h20);
        check("drop_busy", busy, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("drop_return_idle", busy, 0);

        // SUB with a tx_done on the start cycle (ignored), then AND back-to-back
        send_op(8'h09, 8'h04, 8'h22);
        wait_tx(d, cyc);
        check("sub_tx", d, 8'h05);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("early_tx_done_ignored", busy, 1);
        finish_tx();
        check("between_ops_idle", busy, 0);
        send_byte(8'h0C);
        check("and_busy", busy, 1);
        send_byte(8'h0A);
        send_byte(8'h24);
        wait_tx(d, cyc);
        check("and_tx", d, 8'h08);
        finish_tx();
        check("and_idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            send_op(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_tx(d, cyc);
            check($sformatf("vec%0d_tx", i), d, vecs[i].exp);
            finish_tx();
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, op;
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = base_ops[$urandom_range(0, 7)] | 8'($urandom_range(0, 3) << 6);
            send_byte(a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(op);
            wait_tx(d, cyc);
            check($sformatf("rand%0d_tx a=%0h b=%0h op=%0h", i, a, b, op), d, ref_result(a, b, op));
            finish_tx();
        end

        // Flags byte follows the result only when the feature is built in
        stub_mode = 1'b1;
        send_op(8'h01, 8'h02, 8'h20);
        wait_tx(d, cyc);
        check("flags_result_tx", d, 8'h80);
        finish_tx();
`ifdef ALU_CTRL_FLAGS_TX_EN
        wait_tx(d, cyc);
        check("flags_byte_tx", d, 8'h01);
        check("flags_busy", busy, 1);
        finish_tx();
        check("flags_idle", busy, 0);
`else
        check("noflags_idle", busy, 0);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("noflags_no_second_byte", starts, 0);
`endif
        stub_mode = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
